// File: rtl/sudoku_pkg.sv
// Shared types and defaults for the sudoku solve sequencer: FSM states,
// outcome codes and group-index sizing.
package sudoku_pkg;

  localparam int unsigned NGROUPS_DEF = 27;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned STATUS_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [STATUS_W-1:0] {
    STAT_NONE     = 3'd0,
    STAT_SOLVED   = 3'd1,
    STAT_STUCK    = 3'd2,
    STAT_CONFLICT = 3'd3,
    STAT_LIMIT    = 3'd4,
    STAT_ABORTED  = 3'd5
  } status_e;

endpackage

// File: rtl/sudoku_solve_sequencer.sv
// Sequences constraint-propagation passes over all sudoku groups and decides
// when a solve ends (solved, stuck, conflict, pass limit or abort).
module sudoku_solve_sequencer
  import sudoku_pkg::*;
#(
  parameter int unsigned NGROUPS = NGROUPS_DEF,
  parameter int unsigned PW      = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [PW-1:0]       max_pass_i,
  output logic                grp_req_o,
  output logic [IDX_W-1:0]    grp_idx_o,
  input  logic                grp_ack_i,
  input  logic                grp_changed_i,
  input  logic                grp_conflict_i,
  input  logic                solved_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [STATUS_W-1:0] status_o,
  output logic [PW-1:0]       pass_cnt_o,
  output logic                irq_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NGROUPS - 1);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic             req_q, req_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic             irq_q, irq_d;
  logic [PW-1:0]    max_q, max_d;
  logic             chg_q, chg_d;
  logic             abort_q, abort_d;
  logic [PW-1:0]    pass_inc;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= ST_IDLE;
      status_q <= STAT_NONE;
      req_q    <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
      irq_q    <= 1'b0;
      max_q    <= '0;
      chg_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      irq_q    <= irq_d;
      max_q    <= max_d;
      chg_q    <= chg_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    req_d    = req_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    irq_d    = 1'b0;
    max_d    = max_q;
    chg_d    = chg_q;
    abort_d  = abort_q;
    // Pass counter sticks at all-ones rather than wrapping.
    pass_inc = (pass_q == {PW{1'b1}}) ? pass_q : pass_q + PW'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d  = ST_ISSUE;
          status_d = STAT_NONE;
          req_d    = 1'b1;
          idx_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = '0;
          max_d    = max_pass_i;
          chg_d    = 1'b0;
          abort_d  = 1'b0;
        end
      end

      ST_ISSUE: begin
        if (abort_i) abort_d = 1'b1;
        if (grp_ack_i) begin
          chg_d = chg_q | grp_changed_i;
          if (grp_conflict_i || abort_q || abort_i) begin
            state_d  = ST_DONE;
            status_d = grp_conflict_i ? STAT_CONFLICT : STAT_ABORTED;
            req_d    = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            irq_d    = 1'b1;
            abort_d  = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_EVAL;
            req_d   = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_EVAL: begin
        pass_d = pass_inc;
        if (abort_i || solved_i || !chg_q ||
            ((max_q != '0) && (pass_inc == max_q))) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          irq_d   = 1'b1;
          abort_d = 1'b0;
          if (abort_i)       status_d = STAT_ABORTED;
          else if (solved_i) status_d = STAT_SOLVED;
          else if (!chg_q)   status_d = STAT_STUCK;
          else               status_d = STAT_LIMIT;
        end else begin
          state_d = ST_ISSUE;
          req_d   = 1'b1;
          idx_d   = '0;
          chg_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign grp_req_o  = req_q;
  assign grp_idx_o  = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign status_o   = status_q;
  assign pass_cnt_o = pass_q;
  assign irq_o      = irq_q;

endmodule
